// File: rtl/timer_arb_pkg.sv
// Shared types and the round-robin pick helper for the interval timer arbiter.
package timer_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tarb_state_t;

   // Widest request vector rr_pick accepts; callers zero-extend into this.
   localparam int unsigned MaxReq = 32;

   // Winner index: first set bit of req scanning upward from ptr, modulo num.
   // Returns ptr when nothing is set; callers gate on |req.
   function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                           input int unsigned       ptr,
                                           input int unsigned       num);
      int unsigned idx;
      int unsigned pick;
      bit          found;
      idx   = 0;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < MaxReq; i++) begin
         if (i < num && !found) begin
            idx = ptr + i;
            if (idx >= num) idx = idx - num;
            if (req[idx]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear and count enable.
module up_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Clear wins over enable so a load on the same edge starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin sharing of one up_counter among NUM_REQ interval requesters.
module interval_timer_arbiter
   import timer_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_len,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [WIDTH-1:0]         count
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   tarb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [WIDTH-1:0]    len_q, len_d;
   logic [IdxW-1:0]     owner_q, owner_d;
   logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [MaxReq-1:0]   req_ext;
   logic [IdxW-1:0]     winner;
   logic [WIDTH-1:0]    len_sel;
   logic                load_pulse;
   logic                hit;
   logic                cnt_en;
   logic                cnt_rst;

   // Arbitration: winner from the rr pointer and its requested interval.
   always_comb begin
      req_ext = '0;
      req_ext[NUM_REQ-1:0] = req;
      winner = IdxW'(rr_pick(req_ext, 32'(rr_ptr_q), NUM_REQ));
      len_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winner == IdxW'(i)) len_sel = req_len[i*WIDTH +: WIDTH];
      end
   end

   // Equality only: len_q never exceeds the counter range, so hit precedes any wrap.
   assign hit     = (count == len_q);
   assign cnt_en  = tick & (state_q == RUN) & ~hit;
   assign cnt_rst = rst | load_pulse;

   up_counter #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk  (clk),
      .rst  (cnt_rst),
      .en   (cnt_en),
      .count(count)
   );

   // Next-state: grant on arbitration, abort beats expiry, DONE lasts one cycle.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      len_d      = len_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      load_pulse = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d         = '0;
               grant_d[winner] = 1'b1;
               len_d           = len_sel;
               owner_d         = winner;
               rr_ptr_d        = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
               load_pulse      = 1'b1;
               state_d         = RUN;
            end
         end
         RUN: begin
            if (!req[owner_q]) begin
               state_d = IDLE;
               grant_d = '0;
            end else if (hit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, grant, latched interval, owner and rr pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         len_q    <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         len_q    <= len_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign grant = grant_q;
   assign done  = (state_q == DONE) ? grant_q : '0;
   assign busy  = (state_q != IDLE);

endmodule
